// File: rtl/button_event_decoder_pkg.sv
// Shared encodings for button event blocks: FSM states and event indices.
// Optional double-click support is enabled by BUTTON_DOUBLE_CLICK_EN.
package button_event_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_PRESSED        = 3'd1,
      ST_LONG_HELD      = 3'd2,
      ST_WAIT_SECOND    = 3'd3,
      ST_SECOND_PRESSED = 3'd4
   } btn_state_e;

   localparam int EV_SHORT  = 0;
   localparam int EV_LONG   = 1;
   localparam int EV_DOUBLE = 2;
   localparam int EV_NUM    = 3;

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, user events out.
// master = decoder side, slave = consumer/driver side.
interface button_event_decoder_if;

   logic i_btn;
   logic o_short;
   logic o_long;
   logic o_long_held;
   logic o_double;

   modport master (
      input  i_btn,
      output o_short,
      output o_long,
      output o_long_held,
      output o_double
   );

   modport slave (
      output i_btn,
      input  o_short,
      input  o_long,
      input  o_long_held,
      input  o_double
   );

endinterface

// File: rtl/button_event_decoder_edge_detector.sv
// One-cycle delay of the button level with rise/fall strobes.
// The delay register loads even during reset so a held button is no press.
module button_event_decoder_edge_detector (
   input  logic i_clk,
   input  logic i_d,
   output logic o_rise,
   output logic o_fall
);

   logic r_q;

   always_ff @(posedge i_clk) begin
      r_q <= i_d;
   end

   assign o_rise = i_d & ~r_q;
   assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short/long/double events.
// Define BUTTON_DOUBLE_CLICK_EN to build the double-click states.
module button_event_decoder
   import button_event_decoder_pkg::*;
#(
   parameter int p_CNT_WIDTH    = 8,
   parameter int p_LONG_TICKS   = 200,
   parameter int p_DCLICK_TICKS = 100
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   button_event_decoder_if.master bus
);

   localparam logic [p_CNT_WIDTH-1:0] LP_LONG =
      p_CNT_WIDTH'(p_LONG_TICKS);
   localparam logic [p_CNT_WIDTH-1:0] LP_DCLICK =
      p_CNT_WIDTH'(p_DCLICK_TICKS);
   localparam logic [p_CNT_WIDTH-1:0] LP_ONE =
      p_CNT_WIDTH'(1);

   logic                   w_rise;
   logic                   w_fall;
   logic [p_CNT_WIDTH-1:0] w_cnt_inc;
   logic [p_CNT_WIDTH-1:0] w_limit;
   logic                   w_hit;

   btn_state_e             r_state;
   logic [p_CNT_WIDTH-1:0] r_cnt;
   logic [EV_NUM-1:0]      r_evt;
   logic                   r_long_held;

   button_event_decoder_edge_detector u_edge (
      .i_clk  (i_clk),
      .i_d    (bus.i_btn),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // One comparator serves both the hold and the gap window.
   assign w_cnt_inc = r_cnt + LP_ONE;
   assign w_limit   = (r_state == ST_PRESSED) ? LP_LONG : LP_DCLICK;
   assign w_hit     = (w_cnt_inc == w_limit);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_evt       <= '0;
         r_long_held <= 1'b0;
      end else begin
         r_evt <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_state <= ST_PRESSED;
                  r_cnt   <= LP_ONE;
               end
            end
            ST_PRESSED: begin
               if (w_fall) begin
`ifdef BUTTON_DOUBLE_CLICK_EN
                  // The release sample already counts as the first gap sample.
                  if (p_DCLICK_TICKS == 1) begin
                     r_evt[EV_SHORT] <= 1'b1;
                     r_state         <= ST_IDLE;
                  end else begin
                     r_state <= ST_WAIT_SECOND;
                     r_cnt   <= LP_ONE;
                  end
`else
                  r_evt[EV_SHORT] <= 1'b1;
                  r_state         <= ST_IDLE;
`endif
               end else if (w_hit) begin
                  r_evt[EV_LONG] <= 1'b1;
                  r_long_held    <= 1'b1;
                  r_state        <= ST_LONG_HELD;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_LONG_HELD: begin
               if (w_fall) begin
                  r_long_held <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
`ifdef BUTTON_DOUBLE_CLICK_EN
            ST_WAIT_SECOND: begin
               if (w_rise) begin
                  r_state <= ST_SECOND_PRESSED;
               end else if (w_hit) begin
                  r_evt[EV_SHORT] <= 1'b1;
                  r_state         <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
            ST_SECOND_PRESSED: begin
               if (w_fall) begin
                  r_evt[EV_DOUBLE] <= 1'b1;
                  r_state          <= ST_IDLE;
               end
            end
`endif
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_short     = r_evt[EV_SHORT];
   assign bus.o_long      = r_evt[EV_LONG];
   assign bus.o_double    = r_evt[EV_DOUBLE];
   assign bus.o_long_held = r_long_held;

endmodule
